// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// A request holds imem_addr stable until exactly one imem_valid strobe answers it.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_valid
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_valid
  );
endinterface

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC, fetches over a req/valid bus and
// loads the IF/ID register, honouring hazard stalls and EX-stage redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  fetch_unit_if.master       imem,
  output logic               if_id_valid,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_instr,
  output logic [6:0]         opcode,
  output logic [31:0]        fetch_count
);

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] req_addr_reg, req_addr_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic        if_id_valid_reg, if_id_valid_next;
  logic [31:0] if_id_pc_reg, if_id_pc_next;
  logic [31:0] if_id_instr_reg, if_id_instr_next;
  logic [31:0] fetch_count_reg, fetch_count_next;

  logic [31:0] target_aligned;
  logic [31:0] pc_inc;

  assign target_aligned = branch_target & 32'hFFFF_FFFC;
  assign pc_inc         = pc_reg + 32'd4;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= REQ;
      pc_reg          <= RESET_PC;
      req_addr_reg    <= RESET_PC;
      hold_pc_reg     <= 32'h0;
      hold_instr_reg  <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
      if_id_pc_reg    <= 32'h0;
      if_id_instr_reg <= NOP_INSTR;
      fetch_count_reg <= 32'h0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      req_addr_reg    <= req_addr_next;
      hold_pc_reg     <= hold_pc_next;
      hold_instr_reg  <= hold_instr_next;
      if_id_valid_reg <= if_id_valid_next;
      if_id_pc_reg    <= if_id_pc_next;
      if_id_instr_reg <= if_id_instr_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    hold_pc_next     = hold_pc_reg;
    hold_instr_next  = hold_instr_reg;
    if_id_valid_next = if_id_valid_reg;
    if_id_pc_next    = if_id_pc_reg;
    if_id_instr_next = if_id_instr_reg;
    fetch_count_next = fetch_count_reg;

    unique case (state_reg)
      REQ: begin
        if (branch_taken) begin
          pc_next          = target_aligned;
          if_id_valid_next = 1'b0;
          if_id_instr_next = NOP_INSTR;
          // An unanswered request must still be drained before refetching.
          state_next       = imem.imem_valid ? REQ : DRAIN;
        end else if (imem.imem_valid) begin
          pc_next = pc_inc;
          if (stall) begin
            hold_pc_next    = req_addr_reg;
            hold_instr_next = imem.imem_rdata;
            state_next      = HOLD;
          end else begin
            if_id_valid_next = 1'b1;
            if_id_pc_next    = req_addr_reg;
            if_id_instr_next = imem.imem_rdata;
            fetch_count_next = fetch_count_reg + 32'd1;
          end
        end else if (!stall) begin
          if_id_valid_next = 1'b0;
          if_id_instr_next = NOP_INSTR;
        end
      end

      HOLD: begin
        if (branch_taken) begin
          pc_next          = target_aligned;
          if_id_valid_next = 1'b0;
          if_id_instr_next = NOP_INSTR;
          state_next       = REQ;
        end else if (!stall) begin
          if_id_valid_next = 1'b1;
          if_id_pc_next    = hold_pc_reg;
          if_id_instr_next = hold_instr_reg;
          fetch_count_next = fetch_count_reg + 32'd1;
          state_next       = REQ;
        end
      end

      DRAIN: begin
        if (branch_taken) begin
          pc_next          = target_aligned;
          if_id_valid_next = 1'b0;
          if_id_instr_next = NOP_INSTR;
        end
        // The stale response is dropped; the redirect target is fetched next.
        if (imem.imem_valid) begin
          state_next = REQ;
        end
      end

      default: begin
        state_next = REQ;
      end
    endcase

    // The address only moves when a fresh request is about to be issued.
    req_addr_next = (state_next == REQ) ? pc_next : req_addr_reg;
  end

  assign imem.imem_req  = !reset && (state_reg != HOLD);
  assign imem.imem_addr = req_addr_reg;

  assign if_id_valid = if_id_valid_reg;
  assign if_id_pc    = if_id_pc_reg;
  assign if_id_instr = if_id_instr_reg;
  assign opcode      = if_id_instr_reg[6:0];
  assign fetch_count = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural instruction memory (data = addr + 0x100)
// plus a program-order scoreboard checked every cycle, and directed scenarios.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic [6:0]  opcode;
  logic [31:0] fetch_count;

  fetch_unit_if imem ();

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem),
    .if_id_valid   (if_id_valid),
    .if_id_pc      (if_id_pc),
    .if_id_instr   (if_id_instr),
    .opcode        (opcode),
    .fetch_count   (fetch_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_loads  = 0;
  int          mem_lat  = 0;
  int          wait_cnt = 0;
  bit          rand_lat = 1'b0;
  logic [31:0] exp_pc   = RESET_PC;
  logic        last_req = 1'b0;
  logic        last_valid = 1'b0;
  logic        last_reset = 1'b1;
  logic [31:0] last_addr = 32'h0;

  // One clock cycle: memory answers, edge, then the scoreboard judges the result.
  task automatic step();
    logic        p_req, p_valid, p_reset, p_stall, p_branch, pv, loaded;
    logic [31:0] p_addr, p_target, ppc, pinstr, pcount;
    #1;
    p_req  = imem.imem_req;
    p_addr = imem.imem_addr;
    if (p_req && last_req && !last_valid && !last_reset) begin
      n_checks++;
      if (p_addr !== last_addr) begin
        n_fail++;
        $display("FAIL addr_stable: imem_addr=%h required %h", p_addr, last_addr);
      end
    end
    p_valid = !reset && p_req && (wait_cnt >= mem_lat);
    imem.imem_valid = p_valid;
    imem.imem_rdata = p_valid ? p_addr + 32'h100 : 32'hDEAD_BEEF;
    p_reset  = reset;
    p_stall  = stall;
    p_branch = branch_taken;
    p_target = branch_target;
    pv       = if_id_valid;
    ppc      = if_id_pc;
    pinstr   = if_id_instr;
    pcount   = fetch_count;
    @(posedge clk);
    #1;
    last_req   = p_req;
    last_addr  = p_addr;
    last_valid = p_valid;
    last_reset = p_reset;
    if (p_reset) begin
      wait_cnt = 0;
    end else if (p_req) begin
      if (p_valid) begin
        wait_cnt = 0;
        if (rand_lat) mem_lat = $urandom_range(0, 3);
      end else begin
        wait_cnt++;
      end
    end

    if (p_reset) begin
      n_checks++;
      if ({if_id_valid, if_id_pc, if_id_instr, opcode, fetch_count} !==
          {1'b0, 32'h0, NOP, 7'b0010011, 32'h0}) begin
        n_fail++;
        $display("FAIL reset_state: valid=%b pc=%h instr=%h opcode=%h count=%0d required 0/0/%h/13/0",
                 if_id_valid, if_id_pc, if_id_instr, opcode, fetch_count, NOP);
      end
      exp_pc = RESET_PC;
    end else if (p_branch) begin
      n_checks++;
      if (if_id_valid !== 1'b0 || if_id_instr !== NOP || fetch_count !== pcount) begin
        n_fail++;
        $display("FAIL redirect_bubble: valid=%b instr=%h count=%0d required 0/%h/%0d",
                 if_id_valid, if_id_instr, fetch_count, NOP, pcount);
      end
      exp_pc = p_target & 32'hFFFF_FFFC;
    end else begin
      loaded = (fetch_count !== pcount);
      n_checks++;
      if (loaded) begin
        if (fetch_count !== pcount + 32'd1 || if_id_valid !== 1'b1 ||
            if_id_pc !== exp_pc || if_id_instr !== exp_pc + 32'h100) begin
          n_fail++;
          $display("FAIL load_order: count=%0d pc=%h instr=%h valid=%b required %0d/%h/%h/1",
                   fetch_count, if_id_pc, if_id_instr, if_id_valid, pcount + 32'd1,
                   exp_pc, exp_pc + 32'h100);
        end
        exp_pc = exp_pc + 32'd4;
        n_loads++;
      end else if (p_stall) begin
        if ({if_id_valid, if_id_pc, if_id_instr} !== {pv, ppc, pinstr}) begin
          n_fail++;
          $display("FAIL stall_freeze: valid=%b pc=%h instr=%h required %b/%h/%h",
                   if_id_valid, if_id_pc, if_id_instr, pv, ppc, pinstr);
        end
      end else begin
        if (if_id_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL bubble: if_id_valid=%b required 0 (no load, no stall)", if_id_valid);
        end
      end
    end
    n_checks++;
    if (opcode !== if_id_instr[6:0] || (!if_id_valid && if_id_instr !== NOP)) begin
      n_fail++;
      $display("FAIL opcode: opcode=%h instr=%h valid=%b required opcode=instr[6:0], NOP when invalid",
               opcode, if_id_instr, if_id_valid);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    stall = 1'b0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    #1;
    n_checks++;
    if (imem.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_req: imem_req=%b required 0", imem.imem_req);
    end
    step();
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (imem.imem_req !== 1'b1 || imem.imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL first_req: req=%b addr=%h required 1/%h", imem.imem_req, imem.imem_addr, RESET_PC);
    end
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    rand_lat = 1'b0;
    mem_lat  = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'(4 * i) || if_id_instr !== 32'(32'h100 + 4 * i)) begin
        n_fail++;
        $display("FAIL zero_wait: pc=%h instr=%h valid=%b required %h/%h/1",
                 if_id_pc, if_id_instr, if_id_valid, 32'(4 * i), 32'(32'h100 + 4 * i));
      end
    end
    n_checks++;
    if (fetch_count !== 32'd3) begin
      n_fail++;
      $display("FAIL zero_wait_count: fetch_count=%0d required 3", fetch_count);
    end
    $display("test_zero_wait done count=%0d", fetch_count);
  endtask

  task automatic test_latency();
    logic [31:0] a;
    logic        ev;
    mem_lat = 2;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      a = imem.imem_addr;
      step();
      ev = (i % 3 == 2);
      n_checks++;
      if (if_id_valid !== ev || (ev && if_id_pc !== 32'(4 * (i / 3)))) begin
        n_fail++;
        $display("FAIL latency2: cycle %0d valid=%b pc=%h required %b/%h",
                 i, if_id_valid, if_id_pc, ev, 32'(4 * (i / 3)));
      end
      if (!ev) begin
        n_checks++;
        if (imem.imem_addr !== a) begin
          n_fail++;
          $display("FAIL latency2_addr: imem_addr=%h required %h", imem.imem_addr, a);
        end
      end
    end
    $display("test_latency done");
  endtask

  task automatic test_stall_hold();
    mem_lat = 0;
    do_reset();
    step();
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'd4 || imem.imem_req !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: pc=%h valid=%b req=%b required 4/1/0",
                 if_id_pc, if_id_valid, imem.imem_req);
      end
    end
    stall = 1'b0;
    step();
    n_checks++;
    if (if_id_pc !== 32'd8 || if_id_instr !== 32'h108) begin
      n_fail++;
      $display("FAIL stall_release: pc=%h instr=%h required 8/108", if_id_pc, if_id_instr);
    end
    step();
    n_checks++;
    if (if_id_pc !== 32'd12 || fetch_count !== 32'd4) begin
      n_fail++;
      $display("FAIL stall_next: pc=%h count=%0d required c/4", if_id_pc, fetch_count);
    end
    $display("test_stall_hold done");
  endtask

  task automatic test_branch_stall();
    mem_lat = 0;
    do_reset();
    step();
    stall = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    n_checks++;
    if (if_id_valid !== 1'b0 || opcode !== 7'b0010011 || imem.imem_addr !== 32'h40 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL branch_stall: valid=%b opcode=%h addr=%h req=%b required 0/13/40/1",
               if_id_valid, opcode, imem.imem_addr, imem.imem_req);
    end
    step();
    n_checks++;
    if (if_id_pc !== 32'h40 || if_id_instr !== 32'h140) begin
      n_fail++;
      $display("FAIL branch_target_fetch: pc=%h instr=%h required 40/140", if_id_pc, if_id_instr);
    end
    $display("test_branch_stall done");
  endtask

  task automatic test_drain();
    mem_lat = 0;
    do_reset();
    repeat (4) step();
    mem_lat = 2;
    branch_taken = 1'b1;
    branch_target = 32'h83;
    step();
    branch_taken = 1'b0;
    n_checks++;
    if (imem.imem_addr !== 32'h10 || imem.imem_req !== 1'b1 || if_id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_hold1: addr=%h req=%b valid=%b required 10/1/0",
               imem.imem_addr, imem.imem_req, if_id_valid);
    end
    step();
    n_checks++;
    if (imem.imem_addr !== 32'h10 || imem.imem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL drain_hold2: addr=%h req=%b required 10/1", imem.imem_addr, imem.imem_req);
    end
    step();
    n_checks++;
    if (if_id_valid !== 1'b0 || imem.imem_addr !== 32'h80) begin
      n_fail++;
      $display("FAIL drain_discard: valid=%b addr=%h required 0/80", if_id_valid, imem.imem_addr);
    end
    mem_lat = 0;
    step();
    n_checks++;
    if (if_id_pc !== 32'h80 || if_id_instr !== 32'h180) begin
      n_fail++;
      $display("FAIL drain_target: pc=%h instr=%h required 80/180", if_id_pc, if_id_instr);
    end
    $display("test_drain done");
  endtask

  task automatic test_wrap_and_reset();
    mem_lat = 0;
    do_reset();
    step();
    branch_taken = 1'b1;
    branch_target = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    step();
    n_checks++;
    if (if_id_pc !== 32'hFFFF_FFFC || imem.imem_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: pc=%h next_addr=%h required fffffffc/0", if_id_pc, imem.imem_addr);
    end
    step();
    mem_lat = 3;
    step();
    step();
    reset = 1'b1;
    #1;
    n_checks++;
    if (imem.imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_req: imem_req=%b required 0", imem.imem_req);
    end
    step();
    n_checks++;
    if (if_id_valid !== 1'b0 || if_id_pc !== 32'h0 || if_id_instr !== NOP || fetch_count !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset_state: valid=%b pc=%h instr=%h count=%0d required 0/0/%h/0",
               if_id_valid, if_id_pc, if_id_instr, fetch_count, NOP);
    end
    reset = 1'b0;
    mem_lat = 0;
    step();
    n_checks++;
    if (if_id_pc !== RESET_PC || if_id_valid !== 1'b1 || fetch_count !== 32'd1) begin
      n_fail++;
      $display("FAIL post_reset_fetch: pc=%h valid=%b count=%0d required %h/1/1",
               if_id_pc, if_id_valid, fetch_count, RESET_PC);
    end
    $display("test_wrap_and_reset done");
  endtask

  task automatic test_random();
    int loads0;
    rand_lat = 1'b1;
    mem_lat  = 1;
    do_reset();
    loads0 = n_loads;
    for (int i = 0; i < 800; i++) begin
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 11) == 0);
      branch_target = $urandom;
      step();
    end
    stall = 1'b0;
    branch_taken = 1'b0;
    n_checks++;
    if (n_loads - loads0 < 50) begin
      n_fail++;
      $display("FAIL random_progress: loads=%0d required at least 50", n_loads - loads0);
    end
    rand_lat = 1'b0;
    $display("test_random done loads=%0d", n_loads - loads0);
  endtask

  initial begin
    imem.imem_valid = 1'b0;
    imem.imem_rdata = 32'h0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall_hold();
    test_branch_stall();
    test_drain();
    test_wrap_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the pipelined RV32 core: owns the PC, requests instruction words from instruction memory over a req/valid handshake and loads the IF/ID pipeline register. It is the producer of the `opcode` field decoded by the main control unit. It honours the same `stall` bubble signal from the hazard detection unit and accepts branch redirects from the EX stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded by reset.
- `NOP_INSTR`, default 32'h0000_0013 (addi x0,x0,0): instruction presented in IF/ID whenever it holds a bubble.
- `clk` in 1: single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: from the hazard unit. Holds the PC and IF/ID.
- `branch_taken` in 1: redirect request from EX. Valid for one cycle.
- `branch_target` in 32: redirect address. Bits [1:0] are ignored (forced to 0).
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: fetch address. Stable while `imem_req` is high.
- `imem_rdata` in 32: instruction word. Sampled only when `imem_valid` is high.
- `imem_valid` in 1: response strobe. Allowed in the same cycle as `imem_req` or any later cycle. Exactly one strobe per request.
- `if_id_valid` out 1: IF/ID holds a real instruction.
- `if_id_pc` out 32: PC of the IF/ID instruction.
- `if_id_instr` out 32: IF/ID instruction. Equals `NOP_INSTR` when `if_id_valid` is 0.
- `opcode` out 7: `if_id_instr[6:0]`, driven to the control unit.
- `fetch_count` out 32: count of instructions loaded into IF/ID. Wraps modulo 2^32.

## Operation
- Registers:
  - `pc`: next address to fetch.
  - `req_addr`: address of the outstanding request.
  - `hold_buf`: one instruction plus its PC.
  - IF/ID: `if_id_valid`, `if_id_pc`, `if_id_instr`.
  - FSM state.
- FSM states: REQ, HOLD, DRAIN.
- `imem_req` = 1 in REQ and DRAIN, 0 in HOLD and during reset. `imem_addr` = `req_addr`.
- REQ:
  - `req_addr` tracks `pc` when a new request is issued.
  - `imem_valid`=1, `stall`=0, no redirect: IF/ID <= {1, `req_addr`, `imem_rdata`}; `pc` <= `pc`+4; `fetch_count`++; stay in REQ with the next address.
  - `imem_valid`=1, `stall`=1: `hold_buf` <= {`req_addr`, `imem_rdata`}; IF/ID unchanged; `pc` <= `pc`+4; go to HOLD.
  - `imem_valid`=0, `stall`=0: IF/ID <= bubble.
  - `imem_valid`=0, `stall`=1: IF/ID unchanged.
- HOLD:
  - `stall`=1: no request, nothing changes.
  - `stall`=0: IF/ID <= `hold_buf`; `fetch_count`++; go to REQ.
- DRAIN: keep `imem_req` and `req_addr` stable until `imem_valid`. Discard that response, then go to REQ fetching `pc` (the redirect target).
- Redirect (`branch_taken`=1) has the highest priority over `stall` and over any response:
  - `pc` <= {`branch_target`[31:2], 2'b00}.
  - IF/ID <= bubble. `hold_buf` is discarded.
  - In REQ with `imem_valid`=0: go to DRAIN.
  - In REQ with `imem_valid`=1, or in HOLD: the response is discarded; go to REQ with the new `pc`.
  - In DRAIN: `pc` is overwritten with the new target; stay in DRAIN.
- PC arithmetic is 32-bit unsigned and wraps from 32'hFFFF_FFFC to 0.
- Reset values (reset cycle and the state after it):
  - `pc`=`req_addr`=`RESET_PC`, state REQ.
  - `imem_req`=0 while `reset` is high.
  - `if_id_valid`=0, `if_id_pc`=0, `if_id_instr`=`NOP_INSTR`, `opcode`=7'b0010011.
  - `fetch_count`=0.
- Reset mid-transaction abandons the outstanding request. Instruction memory shares `reset` and must drop the request too.

## Timing
- Earliest `imem_req` is the first cycle after `reset` falls.
- A zero-wait memory (`imem_valid` in the same cycle as `imem_req`) gives one instruction per cycle into IF/ID. IF/ID updates on the edge that ends the `imem_valid` cycle.
- Stall latency: `stall` high in cycle N freezes the IF/ID contents at the N+1 edge. The first new IF/ID load happens at the edge ending the first cycle with `stall`=0.
- Redirect in cycle N: IF/ID is a bubble from N+1.
  - No request outstanding: `imem_addr`=target in N+1. The target instruction reaches IF/ID no earlier than the end of N+1.
  - Request outstanding: the target is fetched the cycle after the drained `imem_valid`.
- `opcode` is a register output: no combinational path from `imem_rdata`.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory returning addr+32'h100: `if_id_pc` = 0, 4, 8 on consecutive cycles; `if_id_instr` = 0x100, 0x104, 0x108; `fetch_count`=3.
- 2-cycle memory latency: `if_id_valid` pattern 0,0,1 repeating; `imem_addr` is stable across each wait cycle.
- `stall` high for 3 cycles while a response arrives at PC 8: IF/ID holds PC 4. After release, IF/ID shows PC 8, then PC 12. No instruction is lost or duplicated.
- `branch_taken`, target 0x40, in the same cycle as `stall`=1 and `imem_valid`=1: next cycle IF/ID is a bubble (`opcode`=7'b0010011) and `imem_addr`=0x40.
- Redirect to 0x83 while a 3-cycle request to 0x10 is outstanding: `imem_addr` stays 0x10 until `imem_valid`; the 0x10 data never reaches IF/ID; the next request is to 0x80.
- `pc`=32'hFFFF_FFFC: the following fetch address is 0. Assert `reset` mid-request: the next cycle has `imem_req`=0 and all outputs at their reset values.
